// File: rtl/mips_fetch_stage.sv
// MIPS instruction-fetch stage: PC register, next-PC select and IF/ID pipeline register.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module mips_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_f,
  input  logic        stall_d,
  input  logic        flush_d,
  input  logic        pcsrc_d,
  input  logic        jump_d,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_f,
  output logic [31:0] instr_d,
  output logic [31:0] pcplus4_d,
  output logic        valid_d
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc4_q, ifid_pc4_d;
  logic        ifid_vld_q, ifid_vld_d;
  logic [31:0] pcplus4_f, br_tgt, jmp_tgt;
  logic        ifid_load;

  assign pcplus4_f = pc_q + 32'd4;
  assign br_tgt    = ifid_pc4_q + {{14{ifid_instr_q[15]}}, ifid_instr_q[15:0], 2'b00};
  assign jmp_tgt   = {ifid_pc4_q[31:28], ifid_instr_q[25:0], 2'b00};
  assign ifid_load = !flush_d && !stall_d;

  // Stall masks redirects: the hazard unit re-presents them once the stall lifts.
  always_comb begin
    pc_d = pcplus4_f;
    if (stall_f)      pc_d = pc_q;
    else if (jump_d)  pc_d = jmp_tgt;
    else if (pcsrc_d) pc_d = br_tgt;
  end

  always_comb begin
    ifid_instr_d = ifid_instr_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_vld_d   = ifid_vld_q;
    if (flush_d) begin
      ifid_instr_d = NOP_INSTR;
      ifid_pc4_d   = 32'd0;
      ifid_vld_d   = 1'b0;
    end else if (!stall_d) begin
      ifid_instr_d = imem_rdata;
      ifid_pc4_d   = pcplus4_f;
      ifid_vld_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q         <= RESET_PC;
      ifid_instr_q <= NOP_INSTR;
      ifid_pc4_q   <= 32'd0;
      ifid_vld_q   <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_vld_q   <= ifid_vld_d;
    end
  end

  assign imem_addr = pc_q;
  assign pc_f      = pc_q;
  assign instr_d   = ifid_instr_q;
  assign pcplus4_d = ifid_pc4_q;
  assign valid_d   = ifid_vld_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt_q <= 32'd0;
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      if (ifid_load) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (stall_f)   stall_cnt_q <= stall_cnt_q + 32'd1;
      if (flush_d)   flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign fetch_cnt = fetch_cnt_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_mips_fetch_stage.sv
// Directed bench for mips_fetch_stage: expectations queued per step, checked after each edge.
module tb_mips_fetch_stage;

  logic        clk = 1'b0;
  logic        reset, stall_f, stall_d, flush_d, pcsrc_d, jump_d;
  logic [31:0] imem_addr, imem_rdata, pc_f, instr_d, pcplus4_d;
  logic        valid_d;
  logic        ovr_en;
  logic [31:0] ovr_val;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt, stall_cnt, flush_cnt;
`endif

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        vld;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  // Instruction memory: word = address | 0xA000_0000 unless overridden.
  always_comb imem_rdata = ovr_en ? ovr_val : (imem_addr | 32'hA000_0000);

  mips_fetch_stage dut (
    .clk(clk), .reset(reset), .stall_f(stall_f), .stall_d(stall_d),
    .flush_d(flush_d), .pcsrc_d(pcsrc_d), .jump_d(jump_d),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .pc_f(pc_f),
    .instr_d(instr_d), .pcplus4_d(pcplus4_d), .valid_d(valid_d)
`ifdef FETCH_PERF_CNT_EN
    , .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                      input logic [31:0] pc4, input logic vld);
    exp_t e;
    e.tag = tag; e.pc = pc; e.instr = instr; e.pc4 = pc4; e.vld = vld;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    total++;
    assert (exp_q.size() != 0) else begin
      bad++;
      $error("FAIL %s observed=empty_queue expected=entry", tag);
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk32({e.tag, ".pc_f"}, pc_f, e.pc);
      chk32({e.tag, ".imem_addr"}, imem_addr, e.pc);
      chk32({e.tag, ".instr_d"}, instr_d, e.instr);
      chk32({e.tag, ".pcplus4_d"}, pcplus4_d, e.pc4);
      chk32({e.tag, ".valid_d"}, {31'd0, valid_d}, {31'd0, e.vld});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; stall_f = 1'b0; stall_d = 1'b0; flush_d = 1'b0;
    pcsrc_d = 1'b0; jump_d = 1'b0; ovr_en = 1'b0; ovr_val = 32'd0;
    step("reset", 32'h0, 32'h0, 32'h0, 1'b0);
    reset = 1'b0;

    // Free run
    step("run0", 32'h4, 32'hA000_0000, 32'h4, 1'b1);
    step("run1", 32'h8, 32'hA000_0004, 32'h8, 1'b1);
    step("run2", 32'hC, 32'hA000_0008, 32'hC, 1'b1);

    // Full stall with a pending branch that must be ignored
    stall_f = 1'b1; stall_d = 1'b1; pcsrc_d = 1'b1;
    step("stall0", 32'hC, 32'hA000_0008, 32'hC, 1'b1);
    step("stall1", 32'hC, 32'hA000_0008, 32'hC, 1'b1);
`ifdef FETCH_PERF_CNT_EN
    chk32("stall_cnt", stall_cnt, 32'd2);
    chk32("fetch_cnt", fetch_cnt, 32'd3);
    chk32("flush_cnt", flush_cnt, 32'd0);
`endif
    stall_f = 1'b0; stall_d = 1'b0; pcsrc_d = 1'b0;
    step("release", 32'h10, 32'hA000_000C, 32'h10, 1'b1);

    // Backward branch: 0x14 + (-4 << 2) = 0x04
    ovr_en = 1'b1; ovr_val = 32'h1000_FFFC;
    step("ld_beq", 32'h14, 32'h1000_FFFC, 32'h14, 1'b1);
    ovr_en = 1'b0; pcsrc_d = 1'b1; flush_d = 1'b1;
    step("branch", 32'h04, 32'h0, 32'h0, 1'b0);
    pcsrc_d = 1'b0; flush_d = 1'b0;
    step("br_fetch", 32'h08, 32'hA000_0004, 32'h08, 1'b1);
    for (int a = 8; a <= 32'h1C; a += 4)
      step("walk", 32'(a + 4), 32'hA000_0000 | 32'(a), 32'(a + 4), 1'b1);

    // Jump beats branch when both are asserted
    ovr_en = 1'b1; ovr_val = 32'h0800_0010;
    step("ld_j", 32'h24, 32'h0800_0010, 32'h24, 1'b1);
    ovr_en = 1'b0; jump_d = 1'b1; pcsrc_d = 1'b1; flush_d = 1'b1;
    step("jump", 32'h40, 32'h0, 32'h0, 1'b0);
    jump_d = 1'b0; pcsrc_d = 1'b0; flush_d = 1'b0;
    step("j_fetch", 32'h44, 32'hA000_0040, 32'h44, 1'b1);

    // Flush overrides stall_d
    stall_d = 1'b1; flush_d = 1'b1;
    step("flush_stall", 32'h48, 32'h0, 32'h0, 1'b0);
    stall_d = 1'b0; flush_d = 1'b0;

    // stall_f alone: IF/ID reloads the held PC's instruction
    stall_f = 1'b1;
    step("sf_only0", 32'h48, 32'hA000_0048, 32'h4C, 1'b1);
    step("sf_only1", 32'h48, 32'hA000_0048, 32'h4C, 1'b1);
    stall_f = 1'b0;

    // Jump to 0, then branch by -8 from pcplus4_d=4 to reach 0xFFFF_FFFC
    ovr_en = 1'b1; ovr_val = 32'h0800_0000;
    step("ld_j0", 32'h4C, 32'h0800_0000, 32'h4C, 1'b1);
    ovr_en = 1'b0; jump_d = 1'b1; flush_d = 1'b1;
    step("jump0", 32'h0, 32'h0, 32'h0, 1'b0);
    jump_d = 1'b0; flush_d = 1'b0; ovr_en = 1'b1; ovr_val = 32'h1000_FFFE;
    step("ld_back", 32'h4, 32'h1000_FFFE, 32'h4, 1'b1);
    ovr_en = 1'b0; pcsrc_d = 1'b1; flush_d = 1'b1;
    step("to_top", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0);
    pcsrc_d = 1'b0; flush_d = 1'b0;
    step("wrap", 32'h0, 32'hFFFF_FFFC, 32'h0, 1'b1);

    // Reset during stall with a pending redirect
    stall_f = 1'b1;
    step("pre_rst", 32'h0, 32'hA000_0000, 32'h4, 1'b1);
    reset = 1'b1; pcsrc_d = 1'b1; jump_d = 1'b1;
    step("mid_rst", 32'h0, 32'h0, 32'h0, 1'b0);
`ifdef FETCH_PERF_CNT_EN
    chk32("rst_fetch_cnt", fetch_cnt, 32'd0);
    chk32("rst_stall_cnt", stall_cnt, 32'd0);
    chk32("rst_flush_cnt", flush_cnt, 32'd0);
`endif
    reset = 1'b0; stall_f = 1'b0; pcsrc_d = 1'b0; jump_d = 1'b0;
    step("post_rst", 32'h4, 32'hA000_0000, 32'h4, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
